// File: rtl/gk110_gpio_pkg.sv
// Shared constants for the gk110 GPIO input path.
// Holds the pad count, symbolic pin indices (bit order of every per-pin
// vector) and the default debounce length, which is 1 ms of cpu_clock.
package gk110_gpio_pkg;

   localparam int unsigned N_GPIO = 8;

   // Bit position of each pad within pin_in / pin_stable / edge_flags.
   typedef enum logic [2:0] {
      PIN_D5  = 3'd0,
      PIN_D6  = 3'd1,
      PIN_D9  = 3'd2,
      PIN_D10 = 3'd3,
      PIN_D11 = 3'd4,
      PIN_D12 = 3'd5,
      PIN_D13 = 3'd6,
      PIN_SDA = 3'd7
   } gpio_pin_e;

   localparam int unsigned CPU_FREQ                = 10_000_000;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CPU_FREQ / 1000;
   localparam int unsigned DEFAULT_CNT_WIDTH       = 14;

endpackage

// File: rtl/gpio_debounce_bit.sv
// Single-pin conditioner: two-flop synchroniser, optional debounce counter
// and the accepted (stable) level.
// Ports:
//   cpu_clock, reset  clock and asynchronous active-high reset
//   pin_in            raw asynchronous pad level
//   debounce_en       1 = require DEBOUNCE_CYCLES of a new level, 0 = one cycle
//   init_done         0 while the top is still seeding stable from the synchroniser
//   pin_sync          second synchroniser stage
//   stable            conditioned level
//   rise, fall        high in the cycle whose edge will move stable 0->1 / 1->0
module gpio_debounce_bit
   import gk110_gpio_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
   input  logic cpu_clock,
   input  logic reset,
   input  logic pin_in,
   input  logic debounce_en,
   input  logic init_done,
   output logic pin_sync,
   output logic stable,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_WIDTH-1:0] LAST_FULL = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 s1;
   logic                 s2;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] last;
   logic                 accept;

   // ">=" rather than "==" so that shortening D mid-count (debounce_en
   // dropped) accepts on the next differing edge instead of running on.
   always_comb begin
      last   = debounce_en ? LAST_FULL : '0;
      accept = init_done && (s2 != stable) && (cnt >= last);
   end

   assign rise     = accept &  s2;
   assign fall     = accept & ~s2;
   assign pin_sync = s2;

   always_ff @(posedge cpu_clock or posedge reset) begin
      if (reset) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
      end else begin
         s1 <= pin_in;
         s2 <= s1;
         if (!init_done) begin
            stable <= s2;
            cnt    <= '0;
         end else if (s2 == stable) begin
            cnt <= '0;
         end else if (accept) begin
            stable <= s2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpio_in_conditioner.sv
// GPIO input conditioner between the SB_IO D_IN_0 pads and gk110 pin inputs.
// Synchronises and optionally debounces every pad, latches enabled edges
// into sticky write-1-to-clear flags and raises a masked level interrupt.
// Ports:
//   cpu_clock, reset  clock and asynchronous active-high reset
//   pin_in            raw pad levels (asynchronous)
//   debounce_en       per-pin debounce select
//   rise_en, fall_en  per-pin edge enables for flag setting
//   irq_en            per-pin interrupt mask
//   flag_clr          write-1-to-clear strobe for edge_flags
//   pin_sync          synchronised, undebounced levels
//   pin_stable        conditioned levels to gk110
//   edge_flags        sticky edge flags
//   irq               OR of enabled flags
module gpio_in_conditioner
   import gk110_gpio_pkg::*;
#(
   parameter int unsigned N_PINS          = N_GPIO,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
   input  logic              cpu_clock,
   input  logic              reset,
   input  logic [N_PINS-1:0] pin_in,
   input  logic [N_PINS-1:0] debounce_en,
   input  logic [N_PINS-1:0] rise_en,
   input  logic [N_PINS-1:0] fall_en,
   input  logic [N_PINS-1:0] irq_en,
   input  logic [N_PINS-1:0] flag_clr,
   output logic [N_PINS-1:0] pin_sync,
   output logic [N_PINS-1:0] pin_stable,
   output logic [N_PINS-1:0] edge_flags,
   output logic              irq
);

   logic [1:0]        init_cnt;
   logic              init_done;
   logic [N_PINS-1:0] rise;
   logic [N_PINS-1:0] fall;
   logic [N_PINS-1:0] set;

   // pin_stable is seeded from the synchroniser for three edges after reset
   // so pads already high at power-up do not report a rising edge.
   assign init_done = (init_cnt == 2'd3);

   always_ff @(posedge cpu_clock or posedge reset) begin
      if (reset) begin
         init_cnt <= 2'd0;
      end else if (!init_done) begin
         init_cnt <= init_cnt + 2'd1;
      end
   end

   for (genvar i = 0; i < N_PINS; i++) begin : g_pin
      gpio_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_WIDTH       (CNT_WIDTH)
      ) u_bit (
         .cpu_clock   (cpu_clock),
         .reset       (reset),
         .pin_in      (pin_in[i]),
         .debounce_en (debounce_en[i]),
         .init_done   (init_done),
         .pin_sync    (pin_sync[i]),
         .stable      (pin_stable[i]),
         .rise        (rise[i]),
         .fall        (fall[i])
      );
   end

   assign set = (rise & rise_en) | (fall & fall_en);

   // A set in the same cycle as a clear on that bit leaves the flag at 1.
   always_ff @(posedge cpu_clock or posedge reset) begin
      if (reset) begin
         edge_flags <= '0;
      end else begin
         edge_flags <= (edge_flags & ~flag_clr) | set;
      end
   end

   assign irq = |(edge_flags & irq_en);

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Self-checking bench for gpio_in_conditioner (DEBOUNCE_CYCLES = 4).
// Each task queues the expected {pin_sync, pin_stable, edge_flags, irq}
// for given negedge offsets while driving stimulus, then pops and compares.
module tb_gpio_in_conditioner;

   logic       clk;
   logic       rst;
   logic [7:0] pin_in;
   logic [7:0] debounce_en;
   logic [7:0] rise_en;
   logic [7:0] fall_en;
   logic [7:0] irq_en;
   logic [7:0] flag_clr;
   logic [7:0] pin_sync;
   logic [7:0] pin_stable;
   logic [7:0] edge_flags;
   logic       irq;

   int unsigned checks = 0;
   int unsigned passed = 0;

   typedef struct {
      int unsigned at;
      logic [24:0] val;
      string       tag;
   } exp_t;

   exp_t sb[$];

   gpio_in_conditioner #(
      .N_PINS          (8),
      .DEBOUNCE_CYCLES (4),
      .CNT_WIDTH       (3)
   ) dut (
      .cpu_clock   (clk),
      .reset       (rst),
      .pin_in      (pin_in),
      .debounce_en (debounce_en),
      .rise_en     (rise_en),
      .fall_en     (fall_en),
      .irq_en      (irq_en),
      .flag_clr    (flag_clr),
      .pin_sync    (pin_sync),
      .pin_stable  (pin_stable),
      .edge_flags  (edge_flags),
      .irq         (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [24:0] pk(input logic [7:0] sy, input logic [7:0] st,
                                      input logic [7:0] fl, input logic iq);
      return {sy, st, fl, iq};
   endfunction

   task automatic test_reset();
      exp_t e;
      logic [24:0] obs;
      sb.push_back('{at: 0, val: pk(8'h00, 8'h00, 8'h00, 1'b0), tag: "reset_hold"});
      sb.push_back('{at: 1, val: pk(8'h00, 8'h00, 8'h00, 1'b0), tag: "init_edge1"});
      sb.push_back('{at: 2, val: pk(8'h81, 8'h00, 8'h00, 1'b0), tag: "init_edge2"});
      sb.push_back('{at: 3, val: pk(8'h81, 8'h81, 8'h00, 1'b0), tag: "init_edge3"});
      sb.push_back('{at: 6, val: pk(8'h81, 8'h81, 8'h00, 1'b0), tag: "init_no_flag"});
      for (int unsigned j = 0; j <= 6; j++) begin
         if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         if (j == 0) rst = 1'b0;
      end
   endtask

   task automatic test_debounce();
      exp_t e;
      logic [24:0] obs;
      pin_in = 8'h80;
      sb.push_back('{at: 8,  val: pk(8'h80, 8'h80, 8'h00, 1'b0), tag: "db_fall_quiet"});
      sb.push_back('{at: 10, val: pk(8'h81, 8'h80, 8'h00, 1'b0), tag: "db_sync_first"});
      sb.push_back('{at: 13, val: pk(8'h81, 8'h80, 8'h00, 1'b0), tag: "db_not_yet"});
      sb.push_back('{at: 14, val: pk(8'h81, 8'h81, 8'h01, 1'b1), tag: "db_rise_accept"});
      sb.push_back('{at: 15, val: pk(8'h81, 8'h81, 8'h00, 1'b0), tag: "db_w1c"});
      sb.push_back('{at: 19, val: pk(8'h80, 8'h81, 8'h00, 1'b0), tag: "glitch_sync"});
      sb.push_back('{at: 23, val: pk(8'h81, 8'h81, 8'h00, 1'b0), tag: "glitch_rejected"});
      for (int unsigned j = 0; j <= 23; j++) begin
         if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         case (j)
            8:  begin rise_en = 8'h01; irq_en = 8'h01; pin_in = 8'h81; end
            14: begin flag_clr = 8'h01; fall_en = 8'h01; end
            15: begin flag_clr = 8'h00; pin_in = 8'h80; end
            18: pin_in = 8'h81;
            default: ;
         endcase
      end
   endtask

   task automatic test_no_debounce();
      exp_t e;
      logic [24:0] obs;
      debounce_en = 8'h00; rise_en = 8'h00; fall_en = 8'h00; irq_en = 8'h02;
      pin_in = 8'h83;
      sb.push_back('{at: 4,  val: pk(8'h83, 8'h83, 8'h00, 1'b0), tag: "nd_rise_no_flag"});
      sb.push_back('{at: 6,  val: pk(8'h81, 8'h83, 8'h00, 1'b0), tag: "nd_sync"});
      sb.push_back('{at: 7,  val: pk(8'h81, 8'h81, 8'h02, 1'b1), tag: "nd_fall_3edges"});
      sb.push_back('{at: 9,  val: pk(8'h85, 8'h81, 8'h02, 1'b1), tag: "pulse_sync"});
      sb.push_back('{at: 10, val: pk(8'h81, 8'h85, 8'h06, 1'b1), tag: "pulse_passes"});
      sb.push_back('{at: 11, val: pk(8'h81, 8'h81, 8'h06, 1'b1), tag: "pulse_ends"});
      for (int unsigned j = 0; j <= 11; j++) begin
         if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         case (j)
            4: begin fall_en = 8'h02; pin_in = 8'h81; end
            7: begin rise_en = 8'h04; pin_in = 8'h85; end
            8: pin_in = 8'h81;
            default: ;
         endcase
      end
   endtask

   task automatic test_clear();
      exp_t e;
      logic [24:0] obs;
      flag_clr = 8'h02;
      sb.push_back('{at: 1, val: pk(8'h81, 8'h81, 8'h04, 1'b0), tag: "clr_bit1"});
      sb.push_back('{at: 4, val: pk(8'h83, 8'h83, 8'h04, 1'b0), tag: "clr_rise_masked"});
      sb.push_back('{at: 7, val: pk(8'h81, 8'h81, 8'h02, 1'b1), tag: "set_beats_clr"});
      for (int unsigned j = 0; j <= 7; j++) begin
         if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         case (j)
            1: begin flag_clr = 8'h00; pin_in = 8'h83; end
            4: pin_in = 8'h81;
            6: flag_clr = 8'h06;
            7: flag_clr = 8'h00;
            default: ;
         endcase
      end
   endtask

   task automatic test_all_pins();
      exp_t e;
      logic [24:0] obs;
      rise_en = 8'hFF; fall_en = 8'hFF; irq_en = 8'h00; flag_clr = 8'hFF;
      sb.push_back('{at: 1, val: pk(8'h81, 8'h81, 8'h00, 1'b0), tag: "all_cleared"});
      sb.push_back('{at: 4, val: pk(8'h7E, 8'h7E, 8'hFF, 1'b0), tag: "all_flags_masked"});
      sb.push_back('{at: 5, val: pk(8'h7E, 8'h7E, 8'hFF, 1'b1), tag: "all_irq_sda"});
      for (int unsigned j = 0; j <= 5; j++) begin
         if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         case (j)
            1: begin flag_clr = 8'h00; pin_in = 8'h7E; end
            4: irq_en = 8'h80;
            default: ;
         endcase
      end
   endtask

   task automatic test_debounce_toggle();
      exp_t e;
      logic [24:0] obs;
      debounce_en = 8'hFF;
      pin_in = 8'h7F;
      sb.push_back('{at: 4, val: pk(8'h7F, 8'h7E, 8'hFF, 1'b1), tag: "toggle_pending"});
      sb.push_back('{at: 5, val: pk(8'h7F, 8'h7F, 8'hFF, 1'b1), tag: "toggle_accept_ge"});
      for (int unsigned j = 0; j <= 5; j++) begin
         if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         if (j == 4) debounce_en = 8'h00;
      end
   endtask

   task automatic test_reset_mid();
      exp_t e;
      logic [24:0] obs;
      flag_clr = 8'hFF; debounce_en = 8'hFF; rise_en = 8'hFF; irq_en = 8'hFF;
      pin_in = 8'h7E;
      sb.push_back('{at: 1,  val: pk(8'h7F, 8'h7F, 8'h00, 1'b0), tag: "rm_cleared"});
      sb.push_back('{at: 4,  val: pk(8'h7E, 8'h7F, 8'h00, 1'b0), tag: "rm_counting"});
      sb.push_back('{at: 5,  val: pk(8'h00, 8'h00, 8'h00, 1'b0), tag: "rm_async_reset"});
      sb.push_back('{at: 8,  val: pk(8'hFF, 8'h00, 8'h00, 1'b0), tag: "rm_init_edge2"});
      sb.push_back('{at: 9,  val: pk(8'hFF, 8'hFF, 8'h00, 1'b0), tag: "rm_init_edge3"});
      sb.push_back('{at: 12, val: pk(8'hFF, 8'hFF, 8'h00, 1'b0), tag: "rm_no_spurious"});
      for (int unsigned j = 0; j <= 12; j++) begin
         if (j == 5) #1;
         else if (j != 0) @(negedge clk);
         while (sb.size() != 0 && sb[0].at == j) begin
            e = sb.pop_front();
            obs = {pin_sync, pin_stable, edge_flags, irq};
            checks++;
            if (obs !== e.val)
               $display("FAIL %s: sync/stable/flags/irq observed %h/%h/%h/%b required %h/%h/%h/%b",
                        e.tag, obs[24:17], obs[16:9], obs[8:1], obs[0],
                        e.val[24:17], e.val[16:9], e.val[8:1], e.val[0]);
            else passed++;
         end
         case (j)
            1: flag_clr = 8'h00;
            4: begin #2; rst = 1'b1; end
            5: pin_in = 8'hFF;
            6: rst = 1'b0;
            default: ;
         endcase
      end
   endtask

   initial begin
      rst         = 1'b1;
      pin_in      = 8'h81;
      debounce_en = 8'hFF;
      rise_en     = 8'h00;
      fall_en     = 8'h00;
      irq_en      = 8'h00;
      flag_clr    = 8'h00;
      repeat (3) @(negedge clk);
      test_reset();
      test_debounce();
      test_no_debounce();
      test_clear();
      test_all_pins();
      test_debounce_toggle();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/gpio_in_conditioner.md
Name: gpio_in_conditioner

Overview:
- Sits between the SB_IO D_IN_0 outputs (D5, D6, D9–D13, SDA) and the gk110 pin inputs.
- Synchronises each asynchronous pad input into cpu_clock and optionally debounces it per pin.
- Detects rising and falling edges and latches them as sticky, write-1-to-clear flags.
- Raises a level interrupt to the CPU peripheral logic.

Parameters:
- N_PINS, 8, number of conditioned inputs (bit 0 = D5 … bit 6 = D13, bit 7 = SDA).
- DEBOUNCE_CYCLES, 10000, consecutive cycles a new level must persist before acceptance (≥1; 1 ms at 10 MHz).
- CNT_WIDTH, 14, debounce counter width; must satisfy 2^CNT_WIDTH ≥ DEBOUNCE_CYCLES.

Ports:
- cpu_clock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- pin_in  input  N_PINS  raw pad levels from SB_IO D_IN_0, asynchronous.
- debounce_en  input  N_PINS  per-pin: 1 = debounce, 0 = accept after synchroniser only.
- rise_en  input  N_PINS  per-pin: rising edges set flag.
- fall_en  input  N_PINS  per-pin: falling edges set flag.
- irq_en  input  N_PINS  per-pin interrupt mask.
- flag_clr  input  N_PINS  one-cycle write-1-to-clear strobe.
- pin_sync  output  N_PINS  second synchroniser stage (raw, undebounced).
- pin_stable  output  N_PINS  conditioned level delivered to gk110 D*_in.
- edge_flags  output  N_PINS  sticky edge flags.
- irq  output  1  |(edge_flags & irq_en), combinational from registers.

Behaviour:
- Clock and reset: single clock domain, cpu_clock. Reset is asynchronous, active-high, named reset.
- Reset values: s1 = s2 = 0, pin_stable = 0, edge_flags = 0, irq = 0, all counters 0, init_cnt = 0.
- Synchroniser: two flops per pin, s1 <= pin_in and s2 <= s1. pin_sync = s2.
- Init phase:
  - 2-bit init_cnt counts 0→3 after reset release, then saturates.
  - While init_cnt < 3, each edge does pin_stable <= s2, counters <= 0, and no flag is set.
  - This prevents a spurious edge for pins already high at power-up.
- Debounce (init_cnt == 3), per pin with effective D = debounce_en ? DEBOUNCE_CYCLES : 1. At each edge:
  - If s2 == pin_stable: cnt <= 0.
  - Else, if cnt == D-1: pin_stable <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
- Latency: a pad change arriving before edge k appears on pin_sync after edge k+1 and on pin_stable after edge k+1+D.
  - Debounce off: 3 edges.
  - Any glitch shorter than D cycles at s2 is rejected, and the counter restarts.
- Edge detect, on the same edge that pin_stable changes:
  - rise = pin_stable 0→1, fall = pin_stable 1→0.
  - set = (rise & rise_en) | (fall & fall_en).
  - edge_flags <= (edge_flags & ~flag_clr) | set.
- Simultaneous set and clear on one bit: set wins, and the flag stays 1.
- Flags are sticky; enables affect only new sets. Deasserting rise_en or fall_en does not clear a flag.
- Toggling debounce_en mid-count: the new D applies next edge. If cnt ≥ new D-1, the next differing edge accepts immediately (compare uses ≥).
- Counter never wraps, because acceptance resets it.
- Reset mid-operation: all state returns to reset values immediately (async) and the init phase repeats.
- irq: no extra latency beyond edge_flags.

Decomposition:
- Shared package gk110_gpio_pkg holds:
  - constant N_GPIO = 8
  - pin index constants (PIN_D5 = 0 … PIN_SDA = 7)
  - default DEBOUNCE_CYCLES derived from CPU_FREQ / 1000.
- One natural sub-module, gpio_debounce_bit:
  - Contains the synchroniser, counter and stable register for one pin, with outputs stable, rise and fall.
  - Instantiated N_PINS times via generate.
  - init_cnt, the flag register and irq stay in the top.

Test Plan:
1. Release reset with pin_in = 8'h81 held → pin_stable = 8'h81 after 3 edges, edge_flags = 0, irq = 0.
2. DEBOUNCE_CYCLES = 4, debounce_en = FF, rise_en = 01, irq_en = 01:
   - pin_in[0] 0→1 before edge k → pin_stable[0] = 1 and edge_flags[0] = 1 after edge k+5, irq = 1.
   - pulse 3 cycles wide → no change, flags 0.
3. debounce_en = 00, fall_en = 02: pin_in[1] 1→0 → pin_stable[1] = 0 and edge_flags[1] = 1 after edge k+2; 1-cycle pulse still passes.
4. edge_flags[1] = 1, flag_clr = 02 for one cycle → flag 0 next edge, irq 0. Clear coincident with a new fall set → flag stays 1.
5. All 8 pins toggle together, rise_en = fall_en = FF → edge_flags = FF. irq_en = 00 → irq = 0; irq_en = 80 → irq = 1.
6. Assert reset mid-count (cnt = 2) → all outputs 0 asynchronously. After release with pin high → stable follows in 3 edges, no flag.
